// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: starts the mult or div unit, waits for completion, commits Hi/Lo.
// Optional MD_EARLY_ZERO_EN: flags a zero divisor in START instead of waiting for DIVQ.
module md_sequencer #(
  parameter int unsigned MAX_CYCLES = 64,
  parameter int unsigned CNT_W      = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [1:0]  md_op,
  input  logic        md_abort,
  input  logic        mult_end,
  input  logic        div_end,
  input  logic        DIVQ,
  input  logic [31:0] DIV_B_in,
  output logic        mult_ctrl,
  output logic        div_ctrl,
  output logic        DIVASelect,
  output logic        DIVBSelect,
  output logic        MDSelect,
  output logic        HiCtrl,
  output logic        LoCtrl,
  output logic        md_busy,
  output logic        md_done,
  output logic        md_div_zero,
  output logic        md_timeout
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StWrite,
    StDone,
    StExc,
    StTmo
  } state_e;

  localparam logic [1:0] OpMult = 2'b00;
  localparam logic [1:0] OpDivm = 2'b10;
  localparam logic [1:0] OpRsvd = 2'b11;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             is_mult;
  logic             flag;
  logic             early_zero;
  logic             in_path;

  assign is_mult = (op_q == OpMult);
  // Only the selected unit's completion flag matters.
  assign flag    = is_mult ? mult_end : div_end;

`ifdef MD_EARLY_ZERO_EN
  assign early_zero = !is_mult && (DIV_B_in == '0);
`else
  logic unused_div_b;
  assign unused_div_b = ^DIV_B_in;
  assign early_zero   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (md_start && (md_op != OpRsvd)) begin
          op_d    = md_op;
          state_d = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = early_zero ? StExc : StWait;
      end
      StWait: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CntOne;
        end
        // Completion wins over timeout in the same cycle.
        if (flag) begin
          state_d = (!is_mult && DIVQ) ? StExc : StWrite;
        end else if (cnt_q == CntLast) begin
          state_d = StTmo;
        end
      end
      StWrite: state_d = StDone;
      StDone, StExc, StTmo: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (md_abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpMult;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign in_path = (state_q == StStart) || (state_q == StWait) || (state_q == StWrite);

  always_comb begin
    mult_ctrl   = (state_q == StStart) && is_mult;
    div_ctrl    = (state_q == StStart) && !is_mult && !early_zero;
    DIVASelect  = in_path && (op_q == OpDivm);
    DIVBSelect  = in_path && (op_q == OpDivm);
    MDSelect    = in_path && is_mult;
    HiCtrl      = (state_q == StWrite);
    LoCtrl      = (state_q == StWrite);
    md_busy     = (state_q != StIdle);
    md_done     = (state_q == StDone);
    md_div_zero = (state_q == StExc);
    md_timeout  = (state_q == StTmo);
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed, table-driven bench for md_sequencer; each record is one transaction checked per cycle.
module tb_md_sequencer;

  localparam int MAX = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_start, md_abort, mult_end, div_end, DIVQ;
  logic [1:0]  md_op;
  logic [31:0] DIV_B_in;
  logic        mult_ctrl, div_ctrl, DIVASelect, DIVBSelect, MDSelect;
  logic        HiCtrl, LoCtrl, md_busy, md_done, md_div_zero, md_timeout;
  logic [10:0] outs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  md_sequencer #(.MAX_CYCLES(MAX), .CNT_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .md_start   (md_start),
    .md_op      (md_op),
    .md_abort   (md_abort),
    .mult_end   (mult_end),
    .div_end    (div_end),
    .DIVQ       (DIVQ),
    .DIV_B_in   (DIV_B_in),
    .mult_ctrl  (mult_ctrl),
    .div_ctrl   (div_ctrl),
    .DIVASelect (DIVASelect),
    .DIVBSelect (DIVBSelect),
    .MDSelect   (MDSelect),
    .HiCtrl     (HiCtrl),
    .LoCtrl     (LoCtrl),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .md_div_zero(md_div_zero),
    .md_timeout (md_timeout)
  );

  assign outs = {mult_ctrl, div_ctrl, DIVASelect, DIVBSelect, MDSelect, HiCtrl, LoCtrl,
                 md_busy, md_done, md_div_zero, md_timeout};

  // k: WAIT cycle in which the unit flag is raised (0 = never).
  // abort_at / restart: cycle index (1 = START) at which md_abort / a stray md_start is driven.
  // noise: WAIT cycle in which the other unit's flag is raised.
  typedef struct {
    logic [1:0] op;
    int         k;
    bit         divq;
    int         abort_at;
    int         noise;
    int         restart;
    bit         bzero;
  } vec_t;

  vec_t vecs[14];

  // Expected outputs at sample index j (j = 1 is the START cycle).
  function automatic logic [10:0] exp_out(vec_t v, int j);
    bit   divop, ez;
    int   kind, term, sel_last;
    logic mc, dc, sa, ms, wr, bs, dn, dz, to;
    divop = (v.op != 2'd0);
    ez    = 1'b0;
`ifdef MD_EARLY_ZERO_EN
    ez = divop && v.bzero;
`endif
    if (v.abort_at > 0) begin
      kind = 3; term = v.abort_at; sel_last = v.abort_at;
    end else if (ez) begin
      kind = 1; term = 2; sel_last = 1;
    end else if (v.k > 0) begin
      if (divop && v.divq) begin
        kind = 1; term = v.k + 2; sel_last = v.k + 1;
      end else begin
        kind = 0; term = v.k + 3; sel_last = v.k + 2;
      end
    end else begin
      kind = 2; term = MAX + 2; sel_last = MAX + 1;
    end
    mc = (j == 1) && !divop;
    dc = (j == 1) && divop && !ez;
    sa = (v.op == 2'd2) && (j >= 1) && (j <= sel_last);
    ms = (v.op == 2'd0) && (j >= 1) && (j <= sel_last);
    wr = (kind == 0) && (j == v.k + 2);
    bs = (j >= 1) && (j <= term);
    dn = (kind == 0) && (j == term);
    dz = (kind == 1) && (j == term);
    to = (kind == 2) && (j == term);
    return {mc, dc, sa, sa, ms, wr, wr, bs, dn, dz, to};
  endfunction

  task automatic check(string name, int cyc, logic [10:0] exp);
    n_vec++;
    if (outs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: outputs %b, expected %b", name, cyc, outs, exp);
    end
  endtask

  task automatic clear_inputs();
    md_start = 1'b0;
    md_abort = 1'b0;
    mult_end = 1'b0;
    div_end  = 1'b0;
    DIVQ     = 1'b0;
  endtask

  task automatic run_vec(int idx);
    vec_t  v;
    string name;
    v    = vecs[idx];
    name = $sformatf("vec%0d", idx);
    @(negedge clk);
    check(name, 0, 11'b0);
    md_start = 1'b1;
    md_op    = v.op;
    DIV_B_in = v.bzero ? 32'd0 : 32'd5;
    for (int j = 1; j <= 70; j++) begin
      @(negedge clk);
      clear_inputs();
      check(name, j, exp_out(v, j));
      if ((v.k > 0) && (j == v.k + 1)) begin
        if (v.op == 2'd0) mult_end = 1'b1;
        else              div_end  = 1'b1;
        DIVQ = v.divq;
      end
      if ((v.noise > 0) && (j == v.noise + 1)) begin
        if (v.op == 2'd0) div_end  = 1'b1;
        else              mult_end = 1'b1;
      end
      if (j == v.abort_at) md_abort = 1'b1;
      if (j == v.restart) begin
        md_start = 1'b1;
        md_op    = 2'd1;
      end
    end
    clear_inputs();
  endtask

  initial begin
    //            op    k   divq abort noise restart bzero
    vecs[0]  = '{2'd0, 33, 1'b0, 0,    0,    0,      1'b0};  // MULT long wait
    vecs[1]  = '{2'd2,  5, 1'b0, 0,    0,    0,      1'b0};  // DIVM normal
    vecs[2]  = '{2'd1,  3, 1'b1, 0,    0,    0,      1'b0};  // DIV by zero via DIVQ
    vecs[3]  = '{2'd0,  0, 1'b0, 0,    0,    10,     1'b0};  // MULT timeout, stray start
    vecs[4]  = '{2'd0,  4, 1'b0, 5,    0,    0,      1'b0};  // abort with mult_end same cycle
    vecs[5]  = '{2'd1,  2, 1'b0, 0,    1,    0,      1'b0};  // DIV, stray mult_end ignored
    vecs[6]  = '{2'd0, 64, 1'b0, 0,    0,    0,      1'b0};  // completion on last cycle
    vecs[7]  = '{2'd0,  2, 1'b1, 0,    1,    0,      1'b0};  // MULT ignores DIVQ/div_end
    vecs[8]  = '{2'd2,  1, 1'b1, 0,    0,    0,      1'b0};  // DIVM zero in WAIT cycle 1
    vecs[9]  = '{2'd1,  0, 1'b0, 2,    0,    0,      1'b0};  // abort in WAIT
    vecs[10] = '{2'd2,  0, 1'b0, 1,    0,    0,      1'b0};  // abort in START
    vecs[11] = '{2'd2,  0, 1'b0, 0,    0,    0,      1'b0};  // DIVM timeout
    vecs[12] = '{2'd1,  2, 1'b0, 0,    0,    0,      1'b1};  // DIV with zero divisor input
    vecs[13] = '{2'd0,  1, 1'b0, 0,    0,    0,      1'b0};  // MULT minimum latency

    clear_inputs();
    md_op    = 2'd0;
    DIV_B_in = 32'd5;
    reset    = 1'b1;
    #2;
    check("reset", 0, 11'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(i);

    // Reserved op is ignored.
    @(negedge clk);
    md_start = 1'b1;
    md_op    = 2'd3;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      clear_inputs();
      check("op11_ignored", j, 11'b0);
    end

    // Reset mid-WAIT clears outputs without a clock edge.
    md_start = 1'b1;
    md_op    = 2'd0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      clear_inputs();
    end
    check("pre_reset_wait", 4, 11'b00001001000);
    reset = 1'b1;
    #1;
    check("async_reset", 0, 11'b0);
    @(negedge clk);
    check("reset_held", 1, 11'b0);
    reset = 1'b0;

    run_vec(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
